// File: rtl/clkdiv_sched_pkg.sv
// Shared types and helpers for the clock-divider scheduler.
// Combinational helpers only; no latency.
// No flow control; consumers use these definitions directly.
package clkdiv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  // Smallest ratio that still yields a high phase before the low pulse.
  localparam int unsigned DIV_MIN = 2;

  // Ratios of 0 or 1 cannot form a legal period, so they run at DIV_MIN.
  function automatic logic [31:0] clamp_div(input logic [31:0] r);
    return (r < 32'(DIV_MIN)) ? 32'(DIV_MIN) : r;
  endfunction

endpackage

// File: rtl/clkdiv_scheduler_rr_arbiter.sv
// Round-robin pick of the first active request at or after ptr, wrapping.
// Purely combinational; zero latency.
// No backpressure; the caller decides when the result is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan NUM_REQ slots starting at ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/clkdiv_scheduler.sv
// Shares one programmable clock divider among NUM_REQ requesters (optional CLKDIV_SCHED_PREEMPT_EN).
// Latency: request seen in IDLE at T -> grant at T+2; first clk_div low at T+2+active_div-1.
// No backpressure: requesters hold req level; ownership/ratio change only at period boundaries.
module clkdiv_scheduler
  import clkdiv_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DIV_W        = 8,
  parameter int HOLD_PERIODS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] req_div,
  output logic [NUM_REQ-1:0]       grant,
  output logic [DIV_W-1:0]         active_div,
  output logic                     clk_div,
  output logic                     period_done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [7:0]       HOLD_SAT = 8'(HOLD_PERIODS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  sched_state_e       state_q, state_d;
  logic [DIV_W-1:0]   count_q, count_d;
  logic [7:0]         hold_q, hold_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [DIV_W-1:0]   active_div_q, active_div_d;
  logic               clk_div_q, clk_div_d;
  logic               period_done_q, period_done_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic               owner_req;
  logic               others_req;
  logic               at_end;
  logic [7:0]         hold_inc;
  logic [DIV_W-1:0]   owner_div;
  logic [DIV_W-1:0]   win_div;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next-state, counters and next-cycle output values; outputs are the registered copies.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    hold_d        = hold_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    active_div_d  = active_div_q;
    clk_div_d     = 1'b1;
    period_done_d = 1'b0;

    owner_req  = req[owner_q];
    others_req = |(req & ~grant_q);
    at_end     = (count_q == active_div_q - DIV_ONE);
    hold_inc   = (hold_q >= HOLD_SAT) ? hold_q : hold_q + 8'd1;
    owner_div  = req_div[int'(owner_q)*DIV_W +: DIV_W];
    win_div    = req_div[int'(arb_idx)*DIV_W +: DIV_W];

    case (state_q)
      IDLE: begin
        count_d = '0;
        grant_d = '0;
        if (|req) state_d = ARB;
      end

      ARB: begin
        if (!arb_any) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = RUN;
          count_d = '0;
          hold_d  = '0;
`ifdef CLKDIV_SCHED_PREEMPT_EN
          // The priority requester wins outright and leaves the rotation untouched.
          if (req[0]) begin
            grant_d      = NUM_REQ'(1);
            owner_d      = '0;
            active_div_d = DIV_W'(clamp_div(32'(req_div[DIV_W-1:0])));
          end else
`endif
          begin
            grant_d      = arb_gnt;
            owner_d      = arb_idx;
            ptr_d        = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
            active_div_d = DIV_W'(clamp_div(32'(win_div)));
          end
        end
      end

      RUN: begin
        if (at_end) begin
          count_d = '0;
          hold_d  = hold_inc;
          if (!owner_req) begin
            grant_d = '0;
            state_d = others_req ? ARB : IDLE;
          end
`ifdef CLKDIV_SCHED_PREEMPT_EN
          else if (req[0] && (owner_q != '0)) begin
            grant_d = '0;
            state_d = ARB;
          end
`endif
          else if ((hold_inc >= HOLD_SAT) && others_req) begin
            grant_d = '0;
            state_d = ARB;
          end else begin
            // Ratio updates only here so the running period is never cut short.
            active_div_d = DIV_W'(clamp_div(32'(owner_div)));
          end
        end else begin
          count_d = count_q + DIV_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
    if ((state_d == RUN) && (count_d == active_div_d - DIV_ONE)) begin
      clk_div_d     = 1'b0;
      period_done_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      hold_q        <= '0;
      ptr_q         <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      active_div_q  <= '0;
      clk_div_q     <= 1'b1;
      period_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      hold_q        <= hold_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      active_div_q  <= active_div_d;
      clk_div_q     <= clk_div_d;
      period_done_q <= period_done_d;
      busy_q        <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign active_div  = active_div_q;
  assign clk_div     = clk_div_q;
  assign period_done = period_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_clkdiv_scheduler.sv
// Directed bench for clkdiv_scheduler with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
// Ends with a single summary line.
module tb_clkdiv_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DIV_W   = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DIV_W-1:0] req_div;
  logic [NUM_REQ-1:0]       grant;
  logic [DIV_W-1:0]         active_div;
  logic                     clk_div;
  logic                     period_done;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  clkdiv_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .DIV_W        (DIV_W),
    .HOLD_PERIODS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_div     (req_div),
    .grant       (grant),
    .active_div  (active_div),
    .clk_div     (clk_div),
    .period_done (period_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int i, input logic [DIV_W-1:0] v);
    req_div[i*DIV_W +: DIV_W] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_adiv"},  32'(active_div), 32'h0);
    check({tag, "_clk"},   32'(clk_div), 32'h1);
    check({tag, "_pd"},    32'(period_done), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  // Reset is applied for one edge; outputs must be at reset values right after it.
  task automatic apply_reset(input string tag);
    rst     = 1'b1;
    req     = '0;
    req_div = '0;
    tick();
    check_reset_vals(tag);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_div = '0;
    tick();
    tick();
    check_reset_vals("por");

    // Single requester, ratio 4: grant at +2, low pulse every 4th cycle.
    rst = 1'b0;
    req = 4'b0001;
    set_div(0, 8'd4);
    tick();                                   // E1: ARB
    check("t1_arb_grant", 32'(grant), 32'h0);
    check("t1_arb_busy",  32'(busy), 32'h1);
    check("t1_arb_clk",   32'(clk_div), 32'h1);
    tick();                                   // E2: RUN, count 0
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_adiv",  32'(active_div), 32'd4);
    check("t1_clk0",  32'(clk_div), 32'h1);
    tick();
    tick();                                   // E4
    check("t1_clk2", 32'(clk_div), 32'h1);
    tick();                                   // E5: first low
    check("t1_first_low", 32'(clk_div), 32'h0);
    check("t1_first_pd",  32'(period_done), 32'h1);
    for (int k = 0; k < 8; k++) begin         // E6..E13, lows at E9 and E13
      tick();
      check("t1_clk_pat", 32'(clk_div), ((k == 3) || (k == 7)) ? 32'h0 : 32'h1);
      check("t1_pd_pat",  32'(period_done), ((k == 3) || (k == 7)) ? 32'h1 : 32'h0);
    end

    // Hold expiry: req0 (div 4) keeps 4 periods, one ARB gap, then req2 (div 6).
    apply_reset("t2_rst");
    rst = 1'b0;
    req = 4'b0101;
    set_div(0, 8'd4);
    set_div(2, 8'd6);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("t2_clk_a", 32'(clk_div),
            ((k == 5) || (k == 9) || (k == 13) || (k == 17)) ? 32'h0 : 32'h1);
      if (k >= 2) check("t2_grant_a", 32'(grant), 32'h1);
    end
    tick();                                   // E18: ARB gap
    check("t2_gap_clk",  32'(clk_div), 32'h1);
    check("t2_gap_busy", 32'(busy), 32'h1);
    tick();                                   // E19: new owner
    check("t2_grant_b", 32'(grant), 32'h4);
    check("t2_adiv_b",  32'(active_div), 32'd6);
    for (int k = 20; k <= 30; k++) begin
      tick();
      check("t2_clk_b", 32'(clk_div), ((k == 24) || (k == 30)) ? 32'h0 : 32'h1);
      check("t2_grant_hold", 32'(grant), 32'h4);
    end

    // Ratio 5 -> 3 mid-period, then owner drops mid-period with nobody waiting.
    apply_reset("t3_rst");
    rst = 1'b0;
    req = 4'b0001;
    set_div(0, 8'd5);
    tick();
    tick();                                   // E2
    tick();                                   // E3
    set_div(0, 8'd3);
    tick();                                   // E4
    check("t3_clk_e4", 32'(clk_div), 32'h1);
    tick();                                   // E5
    check("t3_clk_e5",  32'(clk_div), 32'h1);
    check("t3_adiv_e5", 32'(active_div), 32'd5);
    tick();                                   // E6: end of 5-cycle period
    check("t3_low_e6", 32'(clk_div), 32'h0);
    tick();                                   // E7
    check("t3_adiv_e7", 32'(active_div), 32'd3);
    check("t3_clk_e7",  32'(clk_div), 32'h1);
    tick();                                   // E8
    check("t3_clk_e8", 32'(clk_div), 32'h1);
    req = 4'b0000;
    tick();                                   // E9: period still completes
    check("t3_low_e9",   32'(clk_div), 32'h0);
    check("t3_pd_e9",    32'(period_done), 32'h1);
    check("t3_grant_e9", 32'(grant), 32'h1);
    tick();                                   // E10: IDLE
    check("t3_idle_grant", 32'(grant), 32'h0);
    check("t3_idle_busy",  32'(busy), 32'h0);
    check("t3_idle_clk",   32'(clk_div), 32'h1);
    check("t3_idle_pd",    32'(period_done), 32'h0);
    tick();
    check("t3_idle_clk2", 32'(clk_div), 32'h1);

    // Clamp of 0 and 1 to 2, then reset in the middle of RUN.
    apply_reset("t4_rst");
    rst = 1'b0;
    req = 4'b0010;
    set_div(1, 8'd0);
    tick();
    tick();                                   // E2
    check("t4_grant", 32'(grant), 32'h2);
    check("t4_adiv0", 32'(active_div), 32'd2);
    check("t4_clk_e2", 32'(clk_div), 32'h1);
    tick();                                   // E3
    check("t4_clk_e3", 32'(clk_div), 32'h0);
    set_div(1, 8'd1);
    tick();                                   // E4
    check("t4_clk_e4", 32'(clk_div), 32'h1);
    check("t4_adiv1",  32'(active_div), 32'd2);
    tick();                                   // E5
    check("t4_clk_e5", 32'(clk_div), 32'h0);
    tick();                                   // E6
    check("t4_clk_e6", 32'(clk_div), 32'h1);
    req = 4'b0010;
    apply_reset("t4_mid_rst");

`ifdef CLKDIV_SCHED_PREEMPT_EN
    // req1 owns with div 8; req0 rises mid-period and takes over at the boundary.
    rst = 1'b0;
    req = 4'b0010;
    set_div(1, 8'd8);
    set_div(0, 8'd4);
    tick();
    tick();                                   // E2
    check("t5_grant1", 32'(grant), 32'h2);
    tick();                                   // E3
    req = 4'b0011;
    for (int k = 4; k <= 9; k++) begin
      tick();
      check("t5_clk", 32'(clk_div), (k == 9) ? 32'h0 : 32'h1);
    end
    tick();                                   // E10: ARB
    check("t5_gap_grant", 32'(grant), 32'h0);
    tick();                                   // E11
    check("t5_grant0", 32'(grant), 32'h1);
    check("t5_adiv",   32'(active_div), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_scheduler.md
Name: clkdiv_scheduler

Overview:
Shares one programmable clock-divider datapath between NUM_REQ requesters, each supplying its own divide ratio.
- Round-robin arbitration selects an owner, which holds the divider for at least HOLD_PERIODS output periods.
- Ratio changes and ownership changes take effect only at period boundaries, so clk_div never produces a runt period.
- Sits between the block-level clock-enable consumers and the divided-clock/strobe distribution.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIV_W, 8, width of each divide ratio
HOLD_PERIODS, 4, minimum output periods an owner keeps the divider before it can be re-arbitrated while others wait (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request level; held high while divider wanted
req_div  in  NUM_REQ*DIV_W  packed ratios; requester i occupies bits [i*DIV_W +: DIV_W]
grant  out  NUM_REQ  one-hot current owner; all-zero when idle
active_div  out  DIV_W  ratio currently applied (after clamp)
clk_div  out  1  divided output; high except low for 1 cycle at end of each period
period_done  out  1  1-cycle pulse coincident with clk_div low
busy  out  1  high in ARB and RUN

Behaviour:
- Reset values:
  - grant=0, active_div=0, clk_div=1, period_done=0, busy=0.
  - Internal count=0, hold counter=0, round-robin pointer=0 (requester 0 has first priority), state=IDLE.
- Reset mid-operation aborts the current period immediately; outputs reach reset values at the next edge.
- All outputs are registered.
- States:
  - IDLE: clk_div=1, count=0. Goes to ARB if any req is high.
  - ARB (exactly 1 cycle):
    - Picks the first requester with req high, searching from pointer upward and wrapping.
    - Registers grant one-hot and latches active_div from the winner's req_div. Clears count and hold counter. Pointer becomes winner+1 mod NUM_REQ.
    - If req is all-zero on this cycle, returns to IDLE with grant=0.
  - RUN:
    - count increments each cycle from 0 to active_div-1, then wraps to 0.
    - When count==active_div-1: clk_div=0 and period_done=1 on that cycle; the hold counter increments, saturating at HOLD_PERIODS.
    - Period length is exactly active_div cycles.
- Clamp: a req_div value of 0 or 1 is applied as DIV_MIN=2; otherwise it is used unchanged. The maximum period is 2^DIV_W-1 cycles.
- Period-boundary decision, evaluated on the cycle count==active_div-1, in priority order:
  1. Owner's req is low → go to ARB, or IDLE if no other req is high. grant drops on the next cycle.
  2. Hold counter (including this period) ≥ HOLD_PERIODS and another req is high → ARB.
  3. Otherwise stay in RUN and re-latch active_div from the owner's current req_div. The new ratio applies from the next period.
- The owner's req falling mid-period does not truncate the period; the period completes first.
- The owner's req_div changing mid-period is ignored until the boundary.
- Simultaneous owner drop and hold expiry: rule 1 applies (same result, ARB).
- Handover gap: exactly 1 ARB cycle with clk_div=1 between the last low pulse of the old owner and count=0 of the new owner.
- Latency: for a request seen in IDLE at cycle T, grant is high at T+2. The first clk_div low occurs at T+2+active_div-1.

Optional Feature:
Macro CLKDIV_SCHED_PREEMPT_EN.
- Defined: requester 0 is a priority requester. If req[0] is high at a period boundary while another requester owns the divider, the scheduler goes to ARB regardless of the hold counter, and ARB grants requester 0 without advancing the pointer.
- Undefined: requester 0 is an ordinary round-robin participant; no preemption logic is synthesized.

Decomposition:
Package clkdiv_sched_pkg contains:
- state enum {IDLE, ARB, RUN}
- localparam DIV_MIN=2
- a clamp function for ratios

Sub-module rr_arbiter (combinational, parameter NUM_REQ) takes req and pointer and returns a one-hot winner plus an any-request flag.

Test Plan:
- Reset, then req=0001 with req_div[0]=4 → grant=0001 two cycles after req; clk_div low every 4th cycle; period_done aligned with each low cycle.
- Owner req0 (div 4) and req2 (div 6) held high, HOLD_PERIODS=4 → exactly 4 periods of length 4, a 1-cycle ARB gap, then grant=0100 and periods of length 6.
- Owner changes req_div from 5 to 3 mid-period → current period completes at 5 cycles, then 3-cycle periods; no short pulse.
- req_div=0 and req_div=1 → active_div=2; clk_div alternates low/high every other cycle.
- Owner drops req mid-period with none pending → period completes, then IDLE: grant=0, busy=0, clk_div stays 1. Asserting rst during RUN → all outputs at reset values next cycle.
- With CLKDIV_SCHED_PREEMPT_EN, req1 owns (div 8) and req0 rises at cycle 2 → handover at the first period boundary (cycle 7) despite hold counter=1; grant=0001.
